// File: rtl/rr_lock_arbiter.sv
// Registered round-robin N-way arbiter: the winner keeps the grant until it releases,
// drops its request, or reaches MAX_HOLD consecutive cycles.
module rr_lock_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = $clog2(N),
  localparam int HW       = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:N-1]  req,
  input  logic          release_gnt,
  output logic [0:N-1]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [0:N-1]  gnt_n;
  logic          valid_n;
  logic [IW-1:0] id_n;

  logic [IW-1:0] owner_next;
  logic [IW-1:0] scan_base;
  logic          win_found;
  logic [IW-1:0] win_id;
  logic          timed_out;
  logic          end_grant;

  // Explicit wrap so non-power-of-2 N never overflows into an unused index.
  assign owner_next = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
  assign scan_base  = (state == GRANT) ? owner_next : ptr;
  assign timed_out  = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
  assign end_grant  = release_gnt || !req[gnt_id] || timed_out;

  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(scan_base) + i;
      if (idx >= N) idx = idx - N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    gnt_n   = gnt;
    valid_n = gnt_valid;
    id_n    = gnt_id;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n        = GRANT;
          gnt_n          = '0;
          gnt_n[win_id]  = 1'b1;
          valid_n        = 1'b1;
          id_n           = win_id;
          hold_n         = HW'(1);
        end
      end
      GRANT: begin
        if (!end_grant) begin
          if (MAX_HOLD != 0 && hold_cnt != HW'(MAX_HOLD)) hold_n = hold_cnt + 1'b1;
        end else begin
          ptr_n = owner_next;
          if (win_found) begin
            gnt_n         = '0;
            gnt_n[win_id] = 1'b1;
            id_n          = win_id;
            hold_n        = HW'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
            id_n    = '0;
            hold_n  = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_valid <= valid_n;
      gnt_id    <= id_n;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench for rr_lock_arbiter: a behavioural model queues expected grants
// when stimulus is applied; they are popped and compared one cycle later.
module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:N-1]  req;
  logic          release_gnt;
  logic [0:N-1]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:N-1]  g;
    logic          v;
    logic [IW-1:0] id;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic        m_valid = 1'b0;
  int unsigned m_id    = 0;
  int unsigned m_ptr   = 0;
  int unsigned m_hold  = 0;

  int unsigned run_len = 0;
  int unsigned run_max = 0;
  int unsigned last_id = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .release_gnt(release_gnt),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned first_from(input logic [0:N-1] r, input int unsigned start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  task automatic model_step(input logic [0:N-1] r, input logic rel, input logic rst);
    exp_t e;
    if (rst) begin
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_valid) begin
      if (r != '0) begin
        m_id = first_from(r, m_ptr); m_valid = 1'b1; m_hold = 1;
      end
    end else if (rel || !r[m_id] || m_hold == MH) begin
      m_ptr = (m_id + 1) % N;
      if (r != '0) begin
        m_id = first_from(r, m_ptr); m_hold = 1;
      end else begin
        m_valid = 1'b0; m_id = 0; m_hold = 0;
      end
    end else if (m_hold < MH) begin
      m_hold++;
    end
    e.g = '0;
    if (m_valid) e.g[m_id] = 1'b1;
    e.v  = m_valid;
    e.id = IW'(m_id);
    sb.push_back(e);
  endtask

  task automatic step(input logic [0:N-1] r, input logic rel, input logic rst, input string tag);
    exp_t e;
    @(negedge clk);
    req = r; release_gnt = rel; reset = rst;
    model_step(r, rel, rst);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_gnt"},   32'(gnt),       32'(e.g));
      check({tag, "_valid"}, 32'(gnt_valid), 32'(e.v));
      check({tag, "_id"},    32'(gnt_id),    32'(e.id));
    end
    check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    if (gnt_valid && gnt_id == IW'(last_id) && run_len > 0) run_len++;
    else run_len = gnt_valid ? 1 : 0;
    last_id = gnt_id;
    if (run_len > run_max) run_max = run_len;
  endtask

  initial begin
    reset = 1'b1; req = '0; release_gnt = 1'b0;

    // Reset held three cycles with everyone requesting
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, "rst");
    check("rst_gnt_zero", 32'(gnt), 32'd0);
    step(4'b1111, 1'b0, 1'b0, "first");
    check("first_is_req0", 32'(gnt), 32'(4'b1000));
    step(4'b0000, 1'b0, 1'b0, "drain");

    // Single requester with a release pulse -> sole requester re-granted
    step(4'b0010, 1'b0, 1'b0, "single");
    check("single_id", 32'(gnt_id), 32'd2);
    step(4'b0010, 1'b0, 1'b0, "single");
    step(4'b0010, 1'b1, 1'b0, "single_rel");
    check("regrant_id", 32'(gnt_id), 32'd2);
    step(4'b0000, 1'b0, 1'b0, "drain");

    // Round robin: release every grant cycle
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0, "rr");
    step(4'b0000, 1'b0, 1'b0, "drain");

    // Timeout: two requesters, no release
    run_max = 0;
    for (int i = 0; i < 26; i++) step(4'b1100, 1'b0, 1'b0, "tmo");
    check("tmo_max_run", 32'(run_max), 32'(MH));
    step(4'b0000, 1'b0, 1'b0, "drain");

    // Request drop by owner 1 while 0101 requesting
    step(4'b0100, 1'b0, 1'b0, "drop");
    check("drop_owner1", 32'(gnt_id), 32'd1);
    step(4'b0101, 1'b0, 1'b0, "drop");
    step(4'b0001, 1'b0, 1'b0, "drop");
    check("drop_to_3", 32'(gnt), 32'(4'b0001));
    step(4'b0000, 1'b0, 1'b0, "drop_idle");
    check("drop_idle_valid", 32'(gnt_valid), 32'd0);

    // Reset mid-grant with owner 3 at hold_cnt 5
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b0, "own3");
    step(4'b0001, 1'b0, 1'b1, "midrst");
    check("midrst_gnt", 32'(gnt), 32'd0);
    step(4'b1001, 1'b0, 1'b0, "after_rst");
    check("after_rst_req0", 32'(gnt_id), 32'd0);

    // Randomised traffic, occasional release and reset
    for (int i = 0; i < 300; i++)
      step(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0), "rand");

    // Starvation bound: requester 2 holding continuously while others compete
    begin
      int unsigned waited = 0;
      bit got2 = 0;
      step(4'b0000, 1'b0, 1'b1, "starve_rst");
      for (int i = 0; i < (N - 1) * MH + N; i++) begin
        step(4'b1111, 1'b0, 1'b0, "starve");
        if (!got2 && gnt_id == 2 && gnt_valid) got2 = 1;
        if (!got2) waited++;
      end
      check("starve_granted", 32'(got2), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
